// File: rtl/cntr_pkg.sv
// cntr_pkg: state encodings and next-state function for the parametrised counter
package cntr_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'b000,
    LOAD = 3'b001,
    INC  = 3'b010,
    INC2 = 3'b011,
    DEC  = 3'b100,
    DEC2 = 3'b101,
    HOLD = 3'b110
  } state_e;
  // 3'b111 falls through to the IDLE-like path: it is neither INC nor DEC
  function automatic state_e next_state_f(input logic load, input logic en, input logic inc, input logic [2:0] state);
    return load ? LOAD :
           !en  ? HOLD :
           inc  ? (state == INC ? INC2 : INC) :
                  (state == DEC ? DEC2 : DEC);
  endfunction
endpackage

// File: rtl/cntr_param_if.sv
// cntr_param_if: control, data and flag signals of the parametrised counter
interface cntr_param_if #(parameter int WIDTH = 8);
  logic             en;
  logic             load;
  logic             inc;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic [2:0]       state;
  logic             tc_up;
  logic             tc_dn;
  logic             ovf;
  modport master(output en, load, inc, d_in, input d_out, state, tc_up, tc_dn, ovf);
  modport slave(input en, load, inc, d_in, output d_out, state, tc_up, tc_dn, ovf);
endinterface

// File: rtl/cntr_param_ns.sv
// cntr_param_ns: combinational next-state logic
module cntr_param_ns
  import cntr_pkg::*;
(
  input  logic       load,
  input  logic       en,
  input  logic       inc,
  input  logic [2:0] state,
  output state_e     next
);
  assign next = next_state_f(load, en, inc, state);
endmodule

// File: rtl/cntr_param.sv
// cntr_param: up/down counter with load, hold, step, wrap/saturate and tc/ovf flags
module cntr_param
  import cntr_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input logic        clk,
  input logic        reset,
  cntr_param_if.slave bus
);
  localparam logic [WIDTH:0] STEP_W = STEP[WIDTH:0];
  localparam bit             SAT    = SATURATE != 0;
  state_e           state_q, state_nxt;
  logic [WIDTH-1:0] d_q, d_nxt;
  logic [WIDTH:0]   sum, diff;
  logic             up, dn, ovf_q, ovf_nxt;
  cntr_param_ns u_ns (
    .load (bus.load),
    .en   (bus.en),
    .inc  (bus.inc),
    .state(state_q),
    .next (state_nxt)
  );
  // datapath acts on the state being entered, so the action lands on the same edge
  always_comb begin
    up      = state_nxt == INC || state_nxt == INC2;
    dn      = state_nxt == DEC || state_nxt == DEC2;
    sum     = {1'b0, d_q} + STEP_W;
    diff    = {1'b0, d_q} - STEP_W;
    d_nxt   = state_nxt == LOAD ? bus.d_in :
              up ? (sum[WIDTH] && SAT ? {WIDTH{1'b1}} : sum[WIDTH-1:0]) :
              dn ? (diff[WIDTH] && SAT ? {WIDTH{1'b0}} : diff[WIDTH-1:0]) :
              d_q;
    ovf_nxt = (up && sum[WIDTH]) || (dn && diff[WIDTH]);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      d_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      d_q     <= d_nxt;
      ovf_q   <= ovf_nxt;
    end
  end
  assign bus.d_out = d_q;
  assign bus.state = state_q;
  assign bus.ovf   = ovf_q;
  assign bus.tc_up = &d_q;
  assign bus.tc_dn = ~|d_q;
endmodule
